// File: rtl/fetch_ctrl_pkg.sv
// Shared widths, reset PC and buffer entry layout for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

   localparam int ADDR_SIZE  = 31;
   localparam int INSTR_SIZE = 31;

   typedef logic [ADDR_SIZE:0]  addr_t;
   typedef logic [INSTR_SIZE:0] instr_t;

   localparam addr_t FETCH_RESET_PC = '0;

   // One buffer slot: the returned instruction tagged with the PC it was fetched from
   typedef struct packed {
      instr_t instr;
      addr_t  pc;
   } fetch_entry_t;

   function automatic addr_t word_align(input addr_t a);
      return {a[ADDR_SIZE:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_ctrl_buf.sv
// fetch_buf: synchronous FIFO of fetched instructions; flush outranks push and pop.
module fetch_buf
   import fetch_ctrl_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   output logic [CW-1:0] count,
   output fetch_entry_t head
);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;
   fetch_entry_t  mem_q [DEPTH];

   always_comb begin
      do_push  = push && !flush;
      do_pop   = pop && !flush && (count_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         if (do_push && !do_pop)      count_d = count_q + CW'(1);
         else if (!do_push && do_pop) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; only the pointers and count decide what is visible
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

   assert property (@(posedge clk) disable iff (!rst_n) do_push |-> (count_q < CW'(DEPTH)));

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the PC, issues word-aligned imem reads and buffers tagged results for decode.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter addr_t RESET_PC = FETCH_RESET_PC,
   parameter int    DEPTH    = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                redirect,
   input  logic [ADDR_SIZE:0]  redirect_pc,
   output logic [ADDR_SIZE:0]  imem_addr,
   output logic                imem_enable,
   input  logic [INSTR_SIZE:0] imem_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [INSTR_SIZE:0] out_instr,
   output logic [ADDR_SIZE:0]  out_pc
);

   localparam int CW = $clog2(DEPTH) + 1;

   addr_t         fetch_pc_q, fetch_pc_d;
   addr_t         pend_pc_q, pend_pc_d;
   logic          pend_q, pend_d;
   logic [CW-1:0] count;
   logic          do_redirect, push, pop;
   fetch_entry_t  push_data, head;

   assign out_valid = (count != '0);
   assign out_instr = head.instr;
   assign out_pc    = head.pc;

   // Issue only when buffer plus the in-flight response still fit, so a capture never overflows
   always_comb begin
      do_redirect = redirect && reset;
      imem_enable = 1'b0;
      imem_addr   = fetch_pc_q;
      if (do_redirect) begin
         imem_enable = 1'b1;
         imem_addr   = word_align(redirect_pc);
      end else if (reset && ((count + CW'(pend_q)) < CW'(DEPTH))) begin
         imem_enable = 1'b1;
      end
      fetch_pc_d      = imem_enable ? (imem_addr + addr_t'(4)) : fetch_pc_q;
      pend_d          = imem_enable;
      pend_pc_d       = imem_enable ? imem_addr : pend_pc_q;
      push            = pend_q && !do_redirect;
      pop             = out_valid && out_ready && !do_redirect;
      push_data.instr = imem_data;
      push_data.pc    = pend_pc_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_q <= RESET_PC;
         pend_q     <= 1'b0;
         pend_pc_q  <= RESET_PC;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         pend_q     <= pend_d;
         pend_pc_q  <= pend_pc_d;
      end
   end

   fetch_buf #(.DEPTH(DEPTH)) u_buf (
      .clk       (clk),
      .rst_n     (reset),
      .flush     (do_redirect),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .count     (count),
      .head      (head)
   );

endmodule
